// File: rtl/fractal_sync_pkg.sv
// Shared request payload types for the fractal sync network and a width helper
// used by the receive stage and its bus bundle.
package fractal_sync_pkg;

  typedef struct packed {
    logic [1:0] level;
    logic [3:0] id;
    logic [1:0] sig;
  } fsync_req_t;

  // A single port still needs a one-bit index so port_o never collapses to zero width.
  function automatic int port_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fractal_sync_rx_if.sv
// Bundle of the upstream request ports and the merged core-control port of
// fractal_sync_rx, for environments that want to pass the whole bus around.
interface fractal_sync_rx_if #(
  parameter int  N_PORTS = 2,
  parameter type req_t   = logic
);
  localparam int PORT_W = fractal_sync_pkg::port_w(N_PORTS);

  logic [N_PORTS-1:0] req_valid;
  logic [N_PORTS-1:0] req_ready;
  req_t               req [N_PORTS];
  logic               m_valid;
  logic               m_ready;
  req_t               m_req;
  logic [PORT_W-1:0]  port;
  logic               busy;

  // master drives requests into the receiver and accepts its merged output
  modport master (
    output req_valid, req, m_ready,
    input  req_ready, m_valid, m_req, port, busy
  );

  modport slave (
    input  req_valid, req, m_ready,
    output req_ready, m_valid, m_req, port, busy
  );

endinterface

// File: rtl/fractal_sync_fifo.sv
// Small synchronous FIFO with registered occupancy; push is ignored when full
// and pop is ignored when empty, and there is no write-to-read fall-through.
module fractal_sync_fifo #(
  parameter int  DEPTH  = 1,
  parameter type data_t = logic
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  data_t data_i,
  input  logic  pop_i,
  output data_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  data_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; r_count alone decides which entries are visible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/fractal_sync_rx.sv
// Receive stage: buffers each upstream port, then merges them onto one
// core-control port through a round-robin arbiter whose grant locks while stalled.
module fractal_sync_rx #(
  parameter  int  N_PORTS     = 2,
  parameter  int  FIFO_DEPTH  = 1,
  parameter  type fsync_req_t = logic,
  localparam int  PORT_W      = fractal_sync_pkg::port_w(N_PORTS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [N_PORTS-1:0] req_valid_i,
  output logic [N_PORTS-1:0] req_ready_o,
  input  fsync_req_t         req_i [N_PORTS],
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output fsync_req_t         req_o,
  output logic [PORT_W-1:0]  port_o,
  output logic               busy_o
);

  logic [N_PORTS-1:0] w_full;
  logic [N_PORTS-1:0] w_empty;
  logic [N_PORTS-1:0] w_push;
  logic [N_PORTS-1:0] w_pop;
  fsync_req_t         w_data [N_PORTS];

  logic [PORT_W-1:0]  r_ptr;
  logic               r_lock;
  logic [PORT_W-1:0]  r_grant;
  logic [PORT_W-1:0]  w_sel;
  logic [PORT_W-1:0]  w_grant;
  logic [PORT_W-1:0]  w_ptr_next;
  logic               w_fire;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    fractal_sync_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .data_t (fsync_req_t)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_push[g]),
      .data_i  (req_i[g]),
      .pop_i   (w_pop[g]),
      .data_o  (w_data[g]),
      .full_o  (w_full[g]),
      .empty_o (w_empty[g])
    );
  end

  // Ready comes straight from registered occupancy, so a same-cycle pop never frees a slot early.
  assign req_ready_o = ~w_full;
  assign w_push      = req_valid_i & req_ready_o;
  assign busy_o      = |(~w_empty);
  assign req_valid_o = busy_o;

  // NOTE: every variable in a combinational block is given a default first so no latch is inferred.
  always_comb begin
    logic found;
    int   idx;
    w_sel = r_ptr;
    found = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_PORTS; off++) begin
      idx = (int'(r_ptr) + off) % N_PORTS;
      if (!found && !w_empty[idx]) begin
        w_sel = PORT_W'(idx);
        found = 1'b1;
      end
    end
  end

  assign w_grant    = r_lock ? r_grant : w_sel;
  assign w_fire     = req_valid_o & req_ready_i;
  assign w_pop      = w_fire ? (N_PORTS'(1) << w_grant) : '0;
  assign w_ptr_next = (w_grant == PORT_W'(N_PORTS - 1)) ? '0 : w_grant + 1'b1;

  // The lock freezes whichever port was offered while core control stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr   <= '0;
      r_lock  <= 1'b0;
      r_grant <= '0;
    end else if (w_fire) begin
      r_ptr   <= w_ptr_next;
      r_lock  <= 1'b0;
    end else if (req_valid_o) begin
      r_lock  <= 1'b1;
      r_grant <= w_grant;
    end
  end

  assign req_o  = req_valid_o ? w_data[w_grant] : '0;
  assign port_o = req_valid_o ? w_grant : '0;

endmodule

// File: tb/tb_fractal_sync_rx.sv
// Directed bench for fractal_sync_rx with two ports, two-entry buffers and an
// 8-bit payload; each task checks one behaviour against hand-computed values.
module tb_fractal_sync_rx;
  import fractal_sync_pkg::*;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fractal_sync_rx_if #(.N_PORTS(2), .req_t(fsync_req_t)) bus ();

  fractal_sync_rx #(
    .N_PORTS     (2),
    .FIFO_DEPTH  (2),
    .fsync_req_t (fsync_req_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (bus.req_valid),
    .req_ready_o (bus.req_ready),
    .req_i       (bus.req),
    .req_valid_o (bus.m_valid),
    .req_ready_i (bus.m_ready),
    .req_o       (bus.m_req),
    .port_o      (bus.port),
    .busy_o      (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one cycle: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
    bus.req_valid = v;
    bus.req[0]    = fsync_req_t'(d0);
    bus.req[1]    = fsync_req_t'(d1);
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.m_ready = 1'b0;
    drive(2'b00, 8'h00, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.m_ready = 1'b1;
    drive(2'b11, 8'hEE, 8'hDD);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.m_valid, bus.busy, bus.m_req, bus.port, bus.req_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b11}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b busy=%b req=%h port=%h rdy=%b want v=0 busy=0 req=00 port=0 rdy=11",
               bus.m_valid, bus.busy, bus.m_req, bus.port, bus.req_ready);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    bus.m_ready = 1'b1;
    drive(2'b01, 8'h11, 8'h00);
    n_tests++;
    if (bus.req_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL single_ready_after_reset: got %b want 1", bus.req_ready[0]);
    end
    tick();
    drive(2'b00, 8'h00, 8'h00);
    n_tests++;
    if ({bus.m_valid, bus.busy, bus.m_req, bus.port} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin
      n_fail++; $display("FAIL single_cycle1: got v=%b busy=%b req=%h port=%h want v=1 busy=1 req=11 port=0",
                         bus.m_valid, bus.busy, bus.m_req, bus.port);
    end
    tick();
    n_tests++;
    if ({bus.m_valid, bus.busy, bus.m_req, bus.port} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL single_cycle2: got v=%b busy=%b req=%h port=%h want v=0 busy=0 req=00 port=0",
                         bus.m_valid, bus.busy, bus.m_req, bus.port);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    logic       exp_p [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    bus.m_ready = 1'b1;
    drive(2'b11, 8'hA0, 8'hB0);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({bus.m_valid, bus.m_req, bus.port} !== {1'b1, exp_d[i], exp_p[i]}) begin
        n_fail++; $display("FAIL rr_out%0d: got v=%b req=%h port=%h want v=1 req=%h port=%h",
                           i, bus.m_valid, bus.m_req, bus.port, exp_d[i], exp_p[i]);
      end
      // Second pair arrives while port 1 is being popped.
      if (i == 1) drive(2'b11, 8'hC0, 8'hD0);
      else        drive(2'b00, 8'h00, 8'h00);
      tick();
    end
    n_tests++;
    if ({bus.m_valid, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL rr_drained: got v=%b busy=%b want 0 0", bus.m_valid, bus.busy);
    end
  endtask

  task automatic test_grant_lock();
    do_reset();
    bus.m_ready = 1'b1;
    drive(2'b01, 8'h7F, 8'h00);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    tick();
    bus.m_ready = 1'b0;
    drive(2'b01, 8'h01, 8'h00);
    tick();
    drive(2'b10, 8'h00, 8'h02);
    n_tests++;
    if ({bus.m_valid, bus.m_req, bus.port} !== {1'b1, 8'h01, 1'b0}) begin
      n_fail++; $display("FAIL lock_first: got v=%b req=%h port=%h want v=1 req=01 port=0",
                         bus.m_valid, bus.m_req, bus.port);
    end
    tick();
    drive(2'b00, 8'h00, 8'h00);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if ({bus.m_valid, bus.m_req, bus.port} !== {1'b1, 8'h01, 1'b0}) begin
        n_fail++; $display("FAIL lock_hold%0d: got v=%b req=%h port=%h want v=1 req=01 port=0",
                           i, bus.m_valid, bus.m_req, bus.port);
      end
      if (i == 1) bus.m_ready = 1'b1;
      tick();
    end
    n_tests++;
    if ({bus.m_valid, bus.m_req, bus.port} !== {1'b1, 8'h02, 1'b1}) begin
      n_fail++; $display("FAIL lock_second: got v=%b req=%h port=%h want v=1 req=02 port=1",
                         bus.m_valid, bus.m_req, bus.port);
    end
    tick();
    n_tests++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_drained: got v=%b want 0", bus.m_valid);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.m_ready = 1'b0;
    drive(2'b01, 8'h31, 8'h00);
    tick();
    drive(2'b01, 8'h32, 8'h00);
    n_tests++;
    if (bus.req_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL full_ready_one_entry: got %b want 1", bus.req_ready[0]);
    end
    tick();
    drive(2'b01, 8'h33, 8'h00);
    n_tests++;
    if (bus.req_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL full_ready_low: got %b want 0", bus.req_ready[0]);
    end
    tick();
    n_tests++;
    if ({bus.req_ready[0], bus.m_req} !== {1'b0, 8'h31}) begin
      n_fail++; $display("FAIL full_stalled: got rdy=%b req=%h want rdy=0 req=31", bus.req_ready[0], bus.m_req);
    end
    bus.m_ready = 1'b1;
    tick();
    n_tests++;
    if ({bus.req_ready[0], bus.m_valid, bus.m_req} !== {1'b1, 1'b1, 8'h32}) begin
      n_fail++; $display("FAIL full_second: got rdy=%b v=%b req=%h want rdy=1 v=1 req=32",
                         bus.req_ready[0], bus.m_valid, bus.m_req);
    end
    tick();
    drive(2'b00, 8'h00, 8'h00);
    n_tests++;
    if ({bus.m_valid, bus.m_req, bus.port} !== {1'b1, 8'h33, 1'b0}) begin
      n_fail++; $display("FAIL full_third: got v=%b req=%h port=%h want v=1 req=33 port=0",
                         bus.m_valid, bus.m_req, bus.port);
    end
    tick();
    n_tests++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++; $display("FAIL full_drained: got v=%b want 0", bus.m_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3] = '{8'hA1, 8'hA2, 8'hA3};
    do_reset();
    bus.m_ready = 1'b1;
    drive(2'b10, 8'h00, seq[0]);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(2'b10, 8'h00, seq[i+1]);
      else       drive(2'b00, 8'h00, 8'h00);
      n_tests++;
      if ({bus.req_ready[1], bus.m_valid, bus.m_req, bus.port} !== {1'b1, 1'b1, seq[i], 1'b1}) begin
        n_fail++; $display("FAIL b2b_out%0d: got rdy=%b v=%b req=%h port=%h want rdy=1 v=1 req=%h port=1",
                           i, bus.req_ready[1], bus.m_valid, bus.m_req, bus.port, seq[i]);
      end
      tick();
    end
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_drained: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m_ready = 1'b0;
    drive(2'b11, 8'h55, 8'h66);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    n_tests++;
    if ({bus.busy, bus.m_req} !== {1'b1, 8'h55}) begin
      n_fail++; $display("FAIL mid_loaded: got busy=%b req=%h want busy=1 req=55", bus.busy, bus.m_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.m_valid, bus.busy, bus.m_req, bus.port, bus.req_ready} !== {1'b0, 1'b0, 8'h00, 1'b0, 2'b11}) begin
      n_fail++; $display("FAIL mid_reset_async: got v=%b busy=%b req=%h port=%h rdy=%b want v=0 busy=0 req=00 port=0 rdy=11",
                         bus.m_valid, bus.busy, bus.m_req, bus.port, bus.req_ready);
    end
    @(negedge clk);
    rst_n       = 1'b1;
    bus.m_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({bus.m_valid, bus.busy, bus.m_req} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL mid_no_stale: got v=%b busy=%b req=%h want v=0 busy=0 req=00",
                         bus.m_valid, bus.busy, bus.m_req);
    end
    drive(2'b10, 8'h00, 8'h77);
    tick();
    drive(2'b00, 8'h00, 8'h00);
    n_tests++;
    if ({bus.m_valid, bus.m_req, bus.port} !== {1'b1, 8'h77, 1'b1}) begin
      n_fail++; $display("FAIL mid_fresh: got v=%b req=%h port=%h want v=1 req=77 port=1",
                         bus.m_valid, bus.m_req, bus.port);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_grant_lock();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
